hart_issue_scheduler: RTL
=========================

// Module: hart_issue_scheduler
// PURPOSE
// - Barrel-thread issue scheduler for the multithreaded RV32 core. Sits ahead of fetch.
// - Rotates a fixed round-robin slot over all harts, one slot per cycle.
// - Says whether the slot's hart issues this cycle, and when a new start PC must be loaded.
// - Starts harts on request from the host/loader; halts them on request from writeback (ecall/ebreak).
// PARAMETERS
// - NUM_THREADS     `NUM_THREADS (16)  hart count; power of 2, >= 2
// - TIDW            $clog2(NUM_THREADS) thread-id width
// - PCW             12                 PC width (matches STARTUP_ADDR)
// - STARTUP_ADDR    12'h000            PC loaded for autostarted harts
// - AUTOSTART_MASK  'b1                harts that leave reset in PEND (hart 0 by default)
// PORTS
// - clk             in   1            core clock
// - reset           in   1            synchronous, active-high
// - start_valid     in   1            start request
// - start_tid       in   TIDW         hart to start
// - start_pc        in   PCW          start PC for that hart
// - start_ready     out  1            start_tid hart is IDLE; request accepted when valid&ready
// - halt_valid      in   1            halt request from writeback
// - halt_tid        in   TIDW         hart to halt
// - issue_valid     out  1            slot hart issues an instruction this cycle
// - issue_tid       out  TIDW         current slot (thread id)
// - issue_pc_load   out  1            fetch must take issue_pc instead of hart's stored PC
// - issue_pc        out  PCW          start PC of slot hart (meaningful when issue_pc_load)
// - thread_running  out  NUM_THREADS  bit i = hart i in PEND or RUN
// - all_idle        out  1            every hart IDLE
// BEHAVIOUR
// - Synchronous active-high reset, clk and reset only:
//   - slot_q=0.
//   - Each hart: PEND with pc=STARTUP_ADDR if its AUTOSTART_MASK bit is set, else IDLE.
//   - Reset wins over any start/halt in the same cycle; in-flight operations are discarded.
// - Slot counter: slot_q <= slot_q+1 every cycle, wraps NUM_THREADS-1 -> 0; never stalls.
// - issue_tid = slot_q. All issue_* outputs decode registered state only; no input-to-output path.
// - Per-hart FSM (2 bits) and per-hart pc register:
//   - IDLE:
//     - start_valid & start_tid==i -> PEND, pc<=start_pc.
//   - PEND:
//     - In own slot: issue_valid=1, issue_pc_load=1, issue_pc=pc.
//     - State becomes RUN at the end of that cycle.
//   - RUN:
//     - Own slot: issue_valid=1, issue_pc_load=0.
//     - halt_valid & halt_tid==i -> DRAIN.
//   - DRAIN:
//     - Own slot: issue_valid=0.
//     - End of that own-slot cycle -> IDLE. This gives a full rotation for in-flight instructions to retire.
//   - issue_valid=0 in IDLE and in DRAIN.
// - start_ready = (state[start_tid]==IDLE), combinational on start_tid.
//   - A start to a non-IDLE hart is ignored; no state or pc change.
// - Halt to a hart not in RUN (IDLE/PEND/DRAIN): ignored.
// - Start and halt in the same cycle: independent.
//   - A start/halt pair to the same tid cannot both act, because they require different states.
// - Halt arriving in the hart's own RUN slot: that slot still issues; DRAIN starts next cycle.
// - start_pc wider than PCW: not applicable; no truncation performed.
// - all_idle and thread_running are combinational from the state registers.
// CONFIGURATION
// - HART_PERF_COUNTERS_EN defined:
//   - Adds a 32-bit retire-slot counter per hart.
//   - Counter increments in every cycle where issue_valid & issue_tid==i; wraps at 2^32-1 -> 0.
//   - Counter clears on reset and on that hart's accepted start.
//   - Adds ports: perf_sel in TIDW; perf_count out 32 (=counter[perf_sel], combinational).
// - HART_PERF_COUNTERS_EN undefined: no counters, no perf_* ports.
// TESTING (bench at NUM_THREADS=4, PCW=12)
// - T1 autostart:
//   - Release reset, mask 'b1.
//   - Cycle 0: tid0 valid=1, pc_load=1, pc=0x000.
//   - Cycles 1-3: valid=0.
//   - Cycle 4: tid0 valid=1, pc_load=0.
// - T2 start:
//   - Start tid2 pc=0x100, accepted at cycle 5.
//   - Cycle 6 (slot2): valid=1, pc_load=1, pc=0x100.
//   - Cycle 10: valid=1, pc_load=0; thread_running=4'b0101.
// - T3 halt:
//   - Halt tid2 at cycle 11.
//   - Cycle 14 (slot2): valid=0.
//   - Cycle 15: start_ready=1 for tid2; thread_running=4'b0001.
// - T4 illegal requests:
//   - Start tid0 while RUN: start_ready=0, pc unchanged.
//   - Halt tid3 while IDLE: no change.
// - T5 reset mid-run:
//   - Assert reset with harts 0,1,2 RUN.
//   - Next cycle: slot=0, only tid0 PEND, all_idle=0.
//   - Harts 1-2 IDLE.
// - T6 HART_PERF_COUNTERS_EN:
//   - Hart0 running 40 cycles from reset -> perf_count(sel=0)=10.
//   - Restart hart0 after halt -> counter reads 0.

Source files
------------

// File: rtl/hart_issue_scheduler.sv
// Barrel-thread issue scheduler: rotates a round-robin slot over all harts and
// tracks per-hart IDLE/PEND/RUN/DRAIN state. Optional per-hart issue counters: HART_PERF_COUNTERS_EN.
`ifndef NUM_THREADS
`define NUM_THREADS 16
`endif

module hart_issue_scheduler #(
  parameter int                     NUM_THREADS    = `NUM_THREADS,
  parameter int                     TIDW           = $clog2(NUM_THREADS),
  parameter int                     PCW            = 12,
  parameter logic [PCW-1:0]         STARTUP_ADDR   = 12'h000,
  parameter logic [NUM_THREADS-1:0] AUTOSTART_MASK = {{(NUM_THREADS-1){1'b0}}, 1'b1}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  input  logic [TIDW-1:0]        start_tid,
  input  logic [PCW-1:0]         start_pc,
  output logic                   start_ready,
  input  logic                   halt_valid,
  input  logic [TIDW-1:0]        halt_tid,
  output logic                   issue_valid,
  output logic [TIDW-1:0]        issue_tid,
  output logic                   issue_pc_load,
  output logic [PCW-1:0]         issue_pc,
  output logic [NUM_THREADS-1:0] thread_running,
  output logic                   all_idle
`ifdef HART_PERF_COUNTERS_EN
  ,
  input  logic [TIDW-1:0]        perf_sel,
  output logic [31:0]            perf_count
`endif
);

  typedef enum logic [1:0] {
    HART_IDLE  = 2'd0,
    HART_PEND  = 2'd1,
    HART_RUN   = 2'd2,
    HART_DRAIN = 2'd3
  } hart_state_t;

  hart_state_t    state_r [NUM_THREADS];
  logic [PCW-1:0] pc_r    [NUM_THREADS];
  logic [TIDW-1:0] slot_r;

  // Slot rotation and per-hart lifecycle; DRAIN holds a hart off for one full rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_r[i] <= AUTOSTART_MASK[i] ? HART_PEND : HART_IDLE;
        pc_r[i]    <= STARTUP_ADDR;
      end
    end else begin
      slot_r <= slot_r + TIDW'(1);
      for (int i = 0; i < NUM_THREADS; i++) begin
        case (state_r[i])
          HART_IDLE: begin
            if (start_valid && (start_tid == TIDW'(i))) begin
              state_r[i] <= HART_PEND;
              pc_r[i]    <= start_pc;
            end
          end
          HART_PEND: begin
            if (slot_r == TIDW'(i)) begin
              state_r[i] <= HART_RUN;
            end
          end
          HART_RUN: begin
            if (halt_valid && (halt_tid == TIDW'(i))) begin
              state_r[i] <= HART_DRAIN;
            end
          end
          HART_DRAIN: begin
            if (slot_r == TIDW'(i)) begin
              state_r[i] <= HART_IDLE;
            end
          end
          default: begin
            state_r[i] <= HART_IDLE;
          end
        endcase
      end
    end
  end

  // Issue decode from registered slot and state only.
  always_comb begin
    issue_tid     = slot_r;
    issue_pc      = pc_r[slot_r];
    issue_valid   = 1'b0;
    issue_pc_load = 1'b0;
    case (state_r[slot_r])
      HART_PEND: begin
        issue_valid   = 1'b1;
        issue_pc_load = 1'b1;
      end
      HART_RUN: begin
        issue_valid   = 1'b1;
        issue_pc_load = 1'b0;
      end
      default: begin
        issue_valid   = 1'b0;
        issue_pc_load = 1'b0;
      end
    endcase
  end

  // Hart status summaries and start handshake.
  always_comb begin
    all_idle       = 1'b1;
    thread_running = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if ((state_r[i] == HART_PEND) || (state_r[i] == HART_RUN)) begin
        thread_running[i] = 1'b1;
      end else begin
        thread_running[i] = 1'b0;
      end
      if (state_r[i] != HART_IDLE) begin
        all_idle = 1'b0;
      end else begin
        all_idle = all_idle;
      end
    end
    start_ready = (state_r[start_tid] == HART_IDLE);
  end

`ifdef HART_PERF_COUNTERS_EN
  logic [31:0] perf_cnt_r [NUM_THREADS];

  // Issue-slot counters; a start only lands on an IDLE hart, so clear and count never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        perf_cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (start_valid && start_ready && (start_tid == TIDW'(i))) begin
          perf_cnt_r[i] <= 32'd0;
        end else if (issue_valid && (slot_r == TIDW'(i))) begin
          perf_cnt_r[i] <= perf_cnt_r[i] + 32'd1;
        end else begin
          perf_cnt_r[i] <= perf_cnt_r[i];
        end
      end
    end
  end

  assign perf_count = perf_cnt_r[perf_sel];
`endif

endmodule
